ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  width  8   data bits per word
  depth  16  RAM words
  addr   4   address bits
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk          in   1      single clock, all logic on rising edge
  rst          in   1      synchronous, active-high reset
  req0/req1    in   1      requester 0/1 access request, held until granted
  wr0/wr1      in   1      1 = write, 0 = read
  addr0/addr1  in   addr   requester address
  wdata0/wdata1 in  width  requester write data
  gnt0/gnt1    out  1      combinational grant, same cycle as accepted request
  rvalid0/rvalid1 out 1    read data valid for requester 0/1
  rdata0/rdata1 out width  read data, meaningful only while rvalid is high
  ram_we       out  1      registered RAM write enable
  ram_wr_addr  out  addr   registered RAM write address
  ram_wr_data  out  width  registered RAM write data
  ram_re       out  1      registered RAM read enable
  ram_rd_addr  out  addr   registered RAM read address
  ram_d_out    in   width  RAM read data, valid one cycle after ram_re is sampled
REQ-003 Clock SHALL be clk; reset SHALL be rst, synchronous and active-high.

Function
REQ-004 Requesters SHALL hold req, wr, addr and wdata stable until gnt is high, then SHALL drop req or present a new request the next cycle.
REQ-005 With one requester active, that request SHALL be granted in the same cycle.
REQ-006 With both requesters active and different wr values:
  - both SHALL be granted in the same cycle;
  - the writer SHALL use the write port;
  - the reader SHALL use the read port.
REQ-007 Same-address hazard: with both active, different wr values and addr0 == addr1:
  - only the write SHALL be granted;
  - the read SHALL be granted the following cycle.
REQ-008 With both requesters active and equal wr values, only the requester selected by the priority pointer `prio` SHALL be granted.
REQ-009 `prio` SHALL toggle to the losing requester after every cycle in which one request was refused under REQ-007 or REQ-008.
REQ-010 `prio` SHALL hold its value in all other cycles.
REQ-011 A granted write in cycle N SHALL appear on ram_we/ram_wr_addr/ram_wr_data in cycle N+1.
REQ-012 A granted read in cycle N SHALL appear on ram_re/ram_rd_addr in cycle N+1.
REQ-013 ram_we and ram_re SHALL be 0 in any cycle N+1 that follows a cycle N with no grant of that type.
REQ-014 Read latency: a read granted in cycle N SHALL produce rvalid high for exactly one cycle, in cycle N+2, only on the granted requester.
REQ-015 In that cycle rdata SHALL equal ram_d_out.
REQ-016 A 2-stage valid/owner pipeline SHALL track reads in flight.
REQ-017 Back-to-back reads SHALL sustain one rvalid per cycle.
REQ-018 rdata0/rdata1 SHALL be 0 whenever the corresponding rvalid is 0.
REQ-019 Throughput: at most one write and one read SHALL be issued per cycle.
REQ-020 No request SHALL wait more than 2 cycles under continuous contention.

Reset
REQ-021 While rst is high at a clock edge, the following SHALL all clear to 0 on that edge:
  - ram_we, ram_re, ram_wr_addr, ram_wr_data, ram_rd_addr;
  - rvalid0/1, rdata0/1;
  - the read pipeline.
REQ-022 `prio` SHALL reset to 0, giving requester 0 priority.
REQ-023 gnt0/gnt1 SHALL be 0 whenever rst is high.
REQ-024 Reset mid-operation SHALL discard in-flight reads: no rvalid after reset for reads granted before it.
REQ-025 Reset mid-operation SHALL cancel any registered but unissued write.

Verification
REQ-026 The bench SHALL cover these directed scenarios, one line each:
  - Single write/read: req0 write addr 4'h1 data 8'hAA in cycle N -> gnt0 in N, ram_we=1 with addr 1 and data AA in N+1. Then req0 read addr 1 in cycle M -> rvalid0=1 with rdata0=8'hAA in M+2.
  - Write+read, different addresses: req0 write 4'h2/8'hBB with req1 read 4'h1 -> both granted the same cycle; rvalid1 two cycles later with 8'hAA.
  - Same-address hazard: req0 write 4'h3/8'hCC with req1 read 4'h3 -> only gnt0 in cycle N, gnt1 in N+1; rvalid1 in N+3 with rdata1=8'hCC.
  - Round-robin fairness: both requesters issue continuous reads to 4'h1 and 4'h2 for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; rvalid0/rvalid1 alternate starting 2 cycles later.
  - Reset mid-read: read granted in cycle N, rst high in N+1 -> no rvalid in N+2; all outputs 0; prio=0.
  - Idle: no requests for 5 cycles -> ram_we=ram_re=0, no gnt, no rvalid.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a 1W/1R RAM: same-cycle grants,
// registered RAM port drive, and a 2-stage read-return pipeline.
// Params: width (data bits), depth (words), addr (address bits).
// Ports: clk, rst (sync, active-high); req/wr/addr/wdata per requester in;
//   gnt/rvalid/rdata per requester out; ram_we/ram_wr_addr/ram_wr_data,
//   ram_re/ram_rd_addr to the RAM; ram_d_out from the RAM.
module ram_port_arbiter #(
  parameter int width = 8,
  parameter int depth = 16,
  parameter int addr  = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             wr0,
  input  logic             wr1,
  input  logic [addr-1:0]  addr0,
  input  logic [addr-1:0]  addr1,
  input  logic [width-1:0] wdata0,
  input  logic [width-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [width-1:0] rdata0,
  output logic [width-1:0] rdata1,
  output logic             ram_we,
  output logic [addr-1:0]  ram_wr_addr,
  output logic [width-1:0] ram_wr_data,
  output logic             ram_re,
  output logic [addr-1:0]  ram_rd_addr,
  input  logic [width-1:0] ram_d_out
);

  logic             prio_q, prio_d;
  logic             we_q, we_d;
  logic [addr-1:0]  wa_q, wa_d;
  logic [width-1:0] wd_q, wd_d;
  logic             re_q, re_d;
  logic [addr-1:0]  ra_q, ra_d;
  logic             own1_q, own1_d;
  logic             v2_q;
  logic             own2_q;

  logic both, mixed, same;
  logic solo0, solo1, hz, par, tie;
  logic g0, g1;
  logic w0g, w1g, r0g, r1g;

  assign both  = req0 & req1 & ~rst;
  assign mixed = wr0 ^ wr1;
  assign same  = (addr0 == addr1);
  assign solo0 = ~rst & req0 & ~req1;
  assign solo1 = ~rst & req1 & ~req0;
  assign hz    = both & mixed & same;
  assign par   = both & mixed & ~same;
  assign tie   = both & ~mixed;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (1'b1)
      solo0: g0 = 1'b1;
      solo1: g1 = 1'b1;
      // writer goes first so the read sees the new data
      hz: begin
        g0 = wr0;
        g1 = wr1;
      end
      par: begin
        g0 = 1'b1;
        g1 = 1'b1;
      end
      tie: begin
        g0 = ~prio_q;
        g1 = prio_q;
      end
      default: ;
    endcase
  end

  assign gnt0 = g0;
  assign gnt1 = g1;

  // On a refusal priority moves to the loser, i.e. away from the winner.
  always_comb begin
    prio_d = prio_q;
    if ((hz | tie) & ~(g0 & g1))
      prio_d = g0;
  end

  assign w0g = g0 & wr0;
  assign w1g = g1 & wr1;
  assign r0g = g0 & ~wr0;
  assign r1g = g1 & ~wr1;

  always_comb begin
    we_d   = w0g | w1g;
    wa_d   = w0g ? addr0 : addr1;
    wd_d   = w0g ? wdata0 : wdata1;
    re_d   = r0g | r1g;
    own1_d = ~r0g;
    ra_d   = own1_d ? addr1 : addr0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      re_q   <= 1'b0;
      ra_q   <= '0;
      own1_q <= 1'b0;
      v2_q   <= 1'b0;
      own2_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
      we_q   <= we_d;
      if (we_d) begin
        wa_q <= wa_d;
        wd_q <= wd_d;
      end
      re_q   <= re_d;
      if (re_d)
        ra_q <= ra_d;
      own1_q <= own1_d;
      // stage 2: RAM data is on ram_d_out while v2_q is set
      v2_q   <= re_q;
      own2_q <= own1_q;
    end
  end

  assign ram_we      = we_q;
  assign ram_wr_addr = wa_q;
  assign ram_wr_data = wd_q;
  assign ram_re      = re_q;
  assign ram_rd_addr = ra_q;

  assign rvalid0 = v2_q & ~own2_q;
  assign rvalid1 = v2_q & own2_q;
  assign rdata0  = rvalid0 ? ram_d_out : '0;
  assign rdata1  = rvalid1 ? ram_d_out : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed scenarios then random traffic,
// scored against a cycle-indexed reference model and a shadow memory.
module tb_ram_port_arbiter;
  localparam int W = 8;
  localparam int A = 4;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1, wr0, wr1;
  logic [A-1:0] addr0, addr1;
  logic [W-1:0] wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1;
  logic [W-1:0] rdata0, rdata1;
  logic ram_we, ram_re;
  logic [A-1:0] ram_wr_addr, ram_rd_addr;
  logic [W-1:0] ram_wr_data, ram_d_out;
  logic [W-1:0] mem [16] = '{default: '0};

  always #5 clk = ~clk;

  ram_port_arbiter #(.width(W), .depth(16), .addr(A)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_d_out(ram_d_out)
  );

  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_re === 1'b1) ram_d_out <= mem[ram_rd_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit primed = 0;
  bit m_prio = 0;
  logic [W-1:0] shadow [16] = '{default: '0};
  int ex_w_addr [int];
  int ex_w_data [int];
  int ex_r_addr [int];
  int ex_rv_own [int];
  int ex_rv_dat [int];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Grant rules straight from the arbitration policy.
  task automatic model_grant(output bit e0, output bit e1);
    e0 = 0;
    e1 = 0;
    if (rst !== 1'b1) begin
      if (req0 && !req1) e0 = 1;
      else if (req1 && !req0) e1 = 1;
      else if (req0 && req1) begin
        if (wr0 != wr1) begin
          if (addr0 == addr1) begin
            e0 = wr0;
            e1 = wr1;
          end else begin
            e0 = 1;
            e1 = 1;
          end
        end else begin
          e0 = (m_prio == 0);
          e1 = (m_prio == 1);
        end
      end
    end
  endtask

  task automatic settle(output bit e0, output bit e1);
    bit v0, v1;
    int d;
    #1;
    model_grant(e0, e1);
    chk("gnt0", {31'b0, gnt0}, {31'b0, e0});
    chk("gnt1", {31'b0, gnt1}, {31'b0, e1});
    if (primed) begin
      chk("ram_we", {31'b0, ram_we}, ex_w_addr.exists(cyc) ? 1 : 0);
      if (ex_w_addr.exists(cyc)) begin
        chk("ram_wr_addr", {28'b0, ram_wr_addr}, ex_w_addr[cyc]);
        chk("ram_wr_data", {24'b0, ram_wr_data}, ex_w_data[cyc]);
      end
      chk("ram_re", {31'b0, ram_re}, ex_r_addr.exists(cyc) ? 1 : 0);
      if (ex_r_addr.exists(cyc))
        chk("ram_rd_addr", {28'b0, ram_rd_addr}, ex_r_addr[cyc]);
      v0 = ex_rv_own.exists(cyc) && ex_rv_own[cyc] == 0;
      v1 = ex_rv_own.exists(cyc) && ex_rv_own[cyc] == 1;
      d = ex_rv_own.exists(cyc) ? ex_rv_dat[cyc] : 0;
      chk("rvalid0", {31'b0, rvalid0}, {31'b0, v0});
      chk("rvalid1", {31'b0, rvalid1}, {31'b0, v1});
      chk("rdata0", {24'b0, rdata0}, v0 ? d : 0);
      chk("rdata1", {24'b0, rdata1}, v1 ? d : 0);
    end
  endtask

  task automatic advance(input bit e0, input bit e1);
    if (rst === 1'b1) begin
      ex_w_addr.delete(cyc + 1); ex_w_data.delete(cyc + 1);
      ex_r_addr.delete(cyc + 1);
      ex_rv_own.delete(cyc + 1); ex_rv_dat.delete(cyc + 1);
      ex_rv_own.delete(cyc + 2); ex_rv_dat.delete(cyc + 2);
      m_prio = 0;
    end else begin
      if (req0 && req1 && !(e0 && e1)) m_prio = e0;
      if (e0 && !wr0) begin
        ex_r_addr[cyc + 1] = int'(addr0);
        ex_rv_own[cyc + 2] = 0;
        ex_rv_dat[cyc + 2] = int'(shadow[addr0]);
      end
      if (e1 && !wr1) begin
        ex_r_addr[cyc + 1] = int'(addr1);
        ex_rv_own[cyc + 2] = 1;
        ex_rv_dat[cyc + 2] = int'(shadow[addr1]);
      end
      if (e0 && wr0) begin
        ex_w_addr[cyc + 1] = int'(addr0);
        ex_w_data[cyc + 1] = int'(wdata0);
        shadow[addr0] = wdata0;
      end
      if (e1 && wr1) begin
        ex_w_addr[cyc + 1] = int'(addr1);
        ex_w_data[cyc + 1] = int'(wdata1);
        shadow[addr1] = wdata1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    primed = 1;
  endtask

  task automatic idle_cycles(input int n);
    bit a, b;
    for (int i = 0; i < n; i++) begin
      settle(a, b);
      advance(a, b);
    end
  endtask

  initial begin
    bit e0, e1, p0, p1;
    rst = 1; req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    @(posedge clk);
    #1;
    idle_cycles(2);
    rst = 0;

    // reset state
    settle(e0, e1);
    chk("rst_we", {31'b0, ram_we}, 0);
    chk("rst_re", {31'b0, ram_re}, 0);
    chk("rst_wa", {28'b0, ram_wr_addr}, 0);
    chk("rst_wd", {24'b0, ram_wr_data}, 0);
    chk("rst_ra", {28'b0, ram_rd_addr}, 0);
    chk("rst_rv", {30'b0, rvalid1, rvalid0}, 0);
    advance(e0, e1);

    // single write then read
    req0 = 1; wr0 = 1; addr0 = 4'h1; wdata0 = 8'hAA;
    settle(e0, e1);
    chk("s1_gnt0", {31'b0, gnt0}, 1);
    advance(e0, e1);
    req0 = 0;
    settle(e0, e1);
    chk("s1_we", {31'b0, ram_we}, 1);
    chk("s1_wa", {28'b0, ram_wr_addr}, 1);
    chk("s1_wd", {24'b0, ram_wr_data}, 8'hAA);
    advance(e0, e1);
    req0 = 1; wr0 = 0; addr0 = 4'h1;
    settle(e0, e1);
    chk("s1_rgnt0", {31'b0, gnt0}, 1);
    advance(e0, e1);
    req0 = 0;
    idle_cycles(1);
    settle(e0, e1);
    chk("s1_rv0", {31'b0, rvalid0}, 1);
    chk("s1_rd0", {24'b0, rdata0}, 8'hAA);
    advance(e0, e1);

    // write + read, different addresses
    req0 = 1; wr0 = 1; addr0 = 4'h2; wdata0 = 8'hBB;
    req1 = 1; wr1 = 0; addr1 = 4'h1;
    settle(e0, e1);
    chk("s2_gnt", {30'b0, gnt1, gnt0}, 3);
    advance(e0, e1);
    req0 = 0; req1 = 0;
    idle_cycles(1);
    settle(e0, e1);
    chk("s2_rv1", {31'b0, rvalid1}, 1);
    chk("s2_rd1", {24'b0, rdata1}, 8'hAA);
    advance(e0, e1);

    // same-address hazard
    req0 = 1; wr0 = 1; addr0 = 4'h3; wdata0 = 8'hCC;
    req1 = 1; wr1 = 0; addr1 = 4'h3;
    settle(e0, e1);
    chk("s3_gntN", {30'b0, gnt1, gnt0}, 1);
    advance(e0, e1);
    req0 = 0;
    settle(e0, e1);
    chk("s3_gntN1", {30'b0, gnt1, gnt0}, 2);
    advance(e0, e1);
    req1 = 0;
    idle_cycles(1);
    settle(e0, e1);
    chk("s3_rv1", {31'b0, rvalid1}, 1);
    chk("s3_rd1", {24'b0, rdata1}, 8'hCC);
    advance(e0, e1);

    // round-robin fairness right after reset
    rst = 1;
    idle_cycles(1);
    rst = 0;
    req0 = 1; wr0 = 0; addr0 = 4'h1;
    req1 = 1; wr1 = 0; addr1 = 4'h2;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        req0 = 0; req1 = 0;
      end
      settle(e0, e1);
      if (i < 6)
        chk("s4_gnt", {30'b0, gnt1, gnt0}, (i % 2 == 0) ? 1 : 2);
      if (i >= 2)
        chk("s4_rv", {30'b0, rvalid1, rvalid0}, (i % 2 == 0) ? 1 : 2);
      advance(e0, e1);
    end

    // reset mid-read
    req0 = 1; wr0 = 0; addr0 = 4'h1;
    settle(e0, e1);
    chk("s5_gnt0", {31'b0, gnt0}, 1);
    advance(e0, e1);
    req0 = 0; rst = 1;
    settle(e0, e1);
    chk("s5_rstgnt", {30'b0, gnt1, gnt0}, 0);
    advance(e0, e1);
    rst = 0;
    settle(e0, e1);
    chk("s5_rv", {30'b0, rvalid1, rvalid0}, 0);
    chk("s5_re", {31'b0, ram_re}, 0);
    chk("s5_ra", {28'b0, ram_rd_addr}, 0);
    chk("s5_we", {31'b0, ram_we}, 0);
    advance(e0, e1);
    req0 = 1; wr0 = 0; addr0 = 4'h5;
    req1 = 1; wr1 = 0; addr1 = 4'h6;
    settle(e0, e1);
    chk("s5_prio", {30'b0, gnt1, gnt0}, 1);
    advance(e0, e1);
    req0 = 0;
    settle(e0, e1);
    advance(e0, e1);
    req1 = 0;
    idle_cycles(3);

    // idle
    for (int i = 0; i < 5; i++) begin
      settle(e0, e1);
      chk("s6_idle", {26'b0, gnt1, gnt0, rvalid1, rvalid0, ram_re, ram_we}, 0);
      advance(e0, e1);
    end

    // random traffic
    p0 = 0; p1 = 0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(49) == 0);
      if (!req0 || p0) begin
        req0 = ($urandom_range(3) != 0);
        wr0 = 1'($urandom_range(1));
        addr0 = 4'($urandom_range(3));
        wdata0 = 8'($urandom);
      end
      if (!req1 || p1) begin
        req1 = ($urandom_range(3) != 0);
        wr1 = 1'($urandom_range(1));
        addr1 = 4'($urandom_range(3));
        wdata1 = 8'($urandom);
      end
      settle(e0, e1);
      p0 = e0;
      p1 = e1;
      advance(e0, e1);
    end
    rst = 0; req0 = 0; req1 = 0;
    idle_cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
